round_scoreboard: RTL and testbench

Match-level scorekeeper for the tug-of-war game. Consumes the one-cycle round-win pulses produced by the victory checker and keeps a per-player round count. Shows both counts on the otherwise-blank HEX digits and issues a delayed `play_again` pulse that restarts the rope for the next round. Once a player reaches the match target, it latches a match winner and freezes until reset.

---
 rtl/round_scoreboard_if.sv | 26 ++
 rtl/round_scoreboard.sv | 118 +++++++++++
 tb/tb_round_scoreboard.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/round_scoreboard_if.sv
// Bundle of round-win pulses from the victory checker and the scoreboard's
// match status, score and display outputs.
interface round_scoreboard_if;
    logic       left_win;
    logic       right_win;
    logic       play_again;
    logic       match_over;
    logic       left_champ;
    logic       right_champ;
    logic [3:0] left_score;
    logic [3:0] right_score;
    logic [6:0] HEX_L;
    logic [6:0] HEX_R;

    modport master (
        output left_win, right_win,
        input  play_again, match_over, left_champ, right_champ,
        input  left_score, right_score, HEX_L, HEX_R
    );

    modport slave (
        input  left_win, right_win,
        output play_again, match_over, left_champ, right_champ,
        output left_score, right_score, HEX_L, HEX_R
    );
endinterface

// File: rtl/round_scoreboard.sv
// Match-level scorekeeper for tug-of-war: counts round wins, holds each finished
// round before requesting a restart, and latches the match winner.
module round_scoreboard #(
    parameter int unsigned WINS_TO_MATCH = 5,
    parameter int unsigned HOLD_CYCLES   = 4
) (
    input logic             clk,
    input logic             reset,
    round_scoreboard_if.slave bus
);
    localparam int unsigned   CntW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [3:0]    Target   = 4'(WINS_TO_MATCH);
    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
    localparam logic [6:0]    Dash     = 7'b0111111;

    typedef enum logic [1:0] {StPlay, StHold, StDone} state_e;

    state_e          state_q, state_d;
    logic [3:0]      left_score_q, left_score_d;
    logic [3:0]      right_score_q, right_score_d;
    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
    logic            play_again_q, play_again_d;
    logic            left_champ_q, left_champ_d;
    logic            right_champ_q, right_champ_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StPlay;
            left_score_q  <= 4'd0;
            right_score_q <= 4'd0;
            hold_cnt_q    <= '0;
            play_again_q  <= 1'b0;
            left_champ_q  <= 1'b0;
            right_champ_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            left_score_q  <= left_score_d;
            right_score_q <= right_score_d;
            hold_cnt_q    <= hold_cnt_d;
            play_again_q  <= play_again_d;
            left_champ_q  <= left_champ_d;
            right_champ_q <= right_champ_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        left_score_d  = left_score_q;
        right_score_d = right_score_q;
        hold_cnt_d    = hold_cnt_q;
        play_again_d  = 1'b0;
        left_champ_d  = left_champ_q;
        right_champ_d = right_champ_q;
        unique case (state_q)
            StPlay: begin
                if (bus.left_win && bus.right_win) begin
                    // Tie round: no score change, still restart after the hold.
                    state_d    = StHold;
                    hold_cnt_d = HoldLoad;
                end else if (bus.left_win) begin
                    left_score_d = left_score_q + 4'd1;
                    if (left_score_d == Target) begin
                        state_d      = StDone;
                        left_champ_d = 1'b1;
                    end else begin
                        state_d    = StHold;
                        hold_cnt_d = HoldLoad;
                    end
                end else if (bus.right_win) begin
                    right_score_d = right_score_q + 4'd1;
                    if (right_score_d == Target) begin
                        state_d       = StDone;
                        right_champ_d = 1'b1;
                    end else begin
                        state_d    = StHold;
                        hold_cnt_d = HoldLoad;
                    end
                end
            end
            StHold: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end else begin
                    state_d      = StPlay;
                    play_again_d = 1'b1;
                end
            end
            StDone: ;
            default: state_d = StPlay;
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign bus.play_again  = play_again_q;
    assign bus.match_over  = (state_q == StDone);
    assign bus.left_champ  = left_champ_q;
    assign bus.right_champ = right_champ_q;
    assign bus.left_score  = left_score_q;
    assign bus.right_score = right_score_q;
    // Once the match is decided the loser's digit becomes a dash.
    assign bus.HEX_L = (state_q == StDone && right_champ_q) ? Dash : seg7(left_score_q);
    assign bus.HEX_R = (state_q == StDone && left_champ_q) ? Dash : seg7(right_score_q);
endmodule

// File: tb/tb_round_scoreboard.sv
// Directed bench for round_scoreboard with WINS_TO_MATCH=5, HOLD_CYCLES=4.
module tb_round_scoreboard;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   pa_seen;

    round_scoreboard_if sb_if ();

    round_scoreboard #(
        .WINS_TO_MATCH(5),
        .HOLD_CYCLES  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single-cycle pulse sampled at the next edge.
    task automatic pulse(input logic l, input logic r);
        sb_if.left_win  = l;
        sb_if.right_win = r;
        tick();
        sb_if.left_win  = 1'b0;
        sb_if.right_win = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        sb_if.left_win  = 1'b0;
        sb_if.right_win = 1'b0;

        // Reset state
        do_reset();
        chk("rst_lscore", 32'(sb_if.left_score), 32'd0);
        chk("rst_rscore", 32'(sb_if.right_score), 32'd0);
        chk("rst_hexl", 32'(sb_if.HEX_L), 32'h40);
        chk("rst_hexr", 32'(sb_if.HEX_R), 32'h40);
        chk("rst_over", 32'(sb_if.match_over), 32'd0);
        chk("rst_pa", 32'(sb_if.play_again), 32'd0);

        // Single right win; left pulse mid-HOLD is ignored
        pulse(1'b0, 1'b1);
        chk("win_rscore", 32'(sb_if.right_score), 32'd1);
        chk("win_hexr", 32'(sb_if.HEX_R), 32'h79);
        chk("win_pa_n", 32'(sb_if.play_again), 32'd0);
        pulse(1'b1, 1'b0);
        chk("hold_ignore_l", 32'(sb_if.left_score), 32'd0);
        chk("win_pa_n1", 32'(sb_if.play_again), 32'd0);
        tick();
        chk("win_pa_n2", 32'(sb_if.play_again), 32'd0);
        tick();
        chk("win_pa_n3", 32'(sb_if.play_again), 32'd0);
        tick();
        chk("win_pa_n4", 32'(sb_if.play_again), 32'd1);
        tick();
        chk("win_pa_n5", 32'(sb_if.play_again), 32'd0);

        // Match: five left wins
        for (int i = 1; i <= 4; i++) begin
            pulse(1'b1, 1'b0);
            chk("match_lscore", 32'(sb_if.left_score), 32'(i));
            pa_seen = 0;
            for (int k = 1; k <= 4; k++) begin
                tick();
                if (sb_if.play_again) pa_seen = k;
            end
            chk("match_pa_edge", 32'(pa_seen), 32'd4);
        end
        pulse(1'b1, 1'b0);
        chk("match_lscore5", 32'(sb_if.left_score), 32'd5);
        chk("match_over", 32'(sb_if.match_over), 32'd1);
        chk("match_lchamp", 32'(sb_if.left_champ), 32'd1);
        chk("match_rchamp", 32'(sb_if.right_champ), 32'd0);
        chk("match_hexr_dash", 32'(sb_if.HEX_R), 32'h3F);
        chk("match_hexl", 32'(sb_if.HEX_L), 32'h12);
        pa_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (sb_if.play_again) pa_seen++;
        end
        chk("done_no_pa", 32'(pa_seen), 32'd0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        tick();
        chk("done_lscore", 32'(sb_if.left_score), 32'd5);
        chk("done_rscore", 32'(sb_if.right_score), 32'd1);
        chk("done_over", 32'(sb_if.match_over), 32'd1);
        chk("done_pa", 32'(sb_if.play_again), 32'd0);

        // Tie
        do_reset();
        pulse(1'b1, 1'b1);
        chk("tie_lscore", 32'(sb_if.left_score), 32'd0);
        chk("tie_rscore", 32'(sb_if.right_score), 32'd0);
        pa_seen = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (sb_if.play_again) pa_seen = k;
        end
        chk("tie_pa_edge", 32'(pa_seen), 32'd4);

        // Mid-hold reset at 3/2
        for (int i = 0; i < 4; i++) begin
            pulse((i < 3) ? 1'b1 : 1'b0, (i < 3) ? 1'b0 : 1'b1);
            for (int k = 0; k < 4; k++) tick();
        end
        pulse(1'b0, 1'b1);
        chk("mid_lscore3", 32'(sb_if.left_score), 32'd3);
        chk("mid_rscore2", 32'(sb_if.right_score), 32'd2);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_lscore", 32'(sb_if.left_score), 32'd0);
        chk("mid_rst_rscore", 32'(sb_if.right_score), 32'd0);
        chk("mid_rst_hexl", 32'(sb_if.HEX_L), 32'h40);
        chk("mid_rst_pa", 32'(sb_if.play_again), 32'd0);
        pa_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (sb_if.play_again) pa_seen++;
        end
        chk("mid_rst_no_pa", 32'(pa_seen), 32'd0);

        // Reset priority over a coincident win
        reset           = 1'b1;
        sb_if.right_win = 1'b1;
        tick();
        reset           = 1'b0;
        sb_if.right_win = 1'b0;
        chk("prio_rscore", 32'(sb_if.right_score), 32'd0);
        tick();
        chk("prio_rscore2", 32'(sb_if.right_score), 32'd0);
        chk("prio_hexr", 32'(sb_if.HEX_R), 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
